// File: rtl/alu16_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu16_seq : 16-bit add/subtract sequenced as two passes through an    |
// |             external 8-bit ALU (low byte, then high byte).            |
// | Revision  : 1.0                                                        |
// +----------------------------------------------------------------------+
module alu16_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [7:0]  f_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [7:0]  f_out,
   output logic [7:0]  alu_x,
   output logic [7:0]  alu_y,
   output logic [3:0]  alu_func,
   output logic [7:0]  alu_f_in,
   input  logic [7:0]  alu_out,
   input  logic [7:0]  alu_f
);

   localparam logic [3:0] ALU_FUNC_ADD = 4'h0;
   localparam logic [3:0] ALU_FUNC_ADC = 4'h1;
   localparam logic [3:0] ALU_FUNC_SUB = 4'h2;
   localparam logic [3:0] ALU_FUNC_SBC = 4'h3;

   localparam logic [1:0] OP_ADD16 = 2'b00;
   localparam logic [1:0] OP_ADC16 = 2'b01;
   localparam logic [1:0] OP_SBC16 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic [15:0] r_a_q;
   logic [15:0] r_b_q;
   logic [1:0]  r_op_q;
   logic [7:0]  r_f_in_q;
   logic [7:0]  r_result_lo;
   logic        r_carry_lo;
   logic        r_zero_lo;
   logic [7:0]  w_hi_flags;
   logic        w_unused;

   // Only H, V and C are taken from the byte ALU; S and Z are rebuilt for 16 bits.
   assign w_unused = ^{alu_f[7:5], alu_f[3], alu_f[1]};

   function automatic logic [3:0] lo_func(input logic [1:0] o);
      case (o)
         OP_ADD16: lo_func = ALU_FUNC_ADD;
         OP_ADC16: lo_func = ALU_FUNC_ADC;
         OP_SBC16: lo_func = ALU_FUNC_SBC;
         default:  lo_func = ALU_FUNC_SUB;
      endcase
   endfunction

   always_comb begin
      w_hi_flags = 8'h00;
      if (r_op_q == OP_ADD16) begin
         w_hi_flags = {r_f_in_q[7], r_f_in_q[6], r_f_in_q[5], alu_f[4],
                       r_f_in_q[3], r_f_in_q[2], 1'b0, alu_f[0]};
      end else begin
         w_hi_flags = {alu_out[7], (alu_out == 8'h00) && r_zero_lo, r_f_in_q[5], alu_f[4],
                       r_f_in_q[3], alu_f[2], r_op_q[1], alu_f[0]};
      end
   end

   // ALU drive is registered: each transition loads the operands for the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_a_q       <= 16'h0000;
         r_b_q       <= 16'h0000;
         r_op_q      <= 2'b00;
         r_f_in_q    <= 8'h00;
         r_result_lo <= 8'h00;
         r_carry_lo  <= 1'b0;
         r_zero_lo   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= 16'h0000;
         f_out       <= 8'h00;
         alu_x       <= 8'h00;
         alu_y       <= 8'h00;
         alu_func    <= ALU_FUNC_ADD;
         alu_f_in    <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_q    <= a;
                  r_b_q    <= b;
                  r_op_q   <= op;
                  r_f_in_q <= f_in;
                  alu_x    <= a[7:0];
                  alu_y    <= b[7:0];
                  alu_f_in <= f_in;
                  alu_func <= lo_func(op);
                  busy     <= 1'b1;
                  r_state  <= ST_LO;
               end
            end
            ST_LO: begin
               r_result_lo <= alu_out;
               r_carry_lo  <= alu_f[0];
               r_zero_lo   <= (alu_out == 8'h00);
               alu_x       <= r_a_q[15:8];
               alu_y       <= r_b_q[15:8];
               alu_f_in    <= {r_f_in_q[7:1], alu_f[0]};
               alu_func    <= r_op_q[1] ? ALU_FUNC_SBC : ALU_FUNC_ADC;
               r_state     <= ST_HI;
            end
            ST_HI: begin
               result   <= {alu_out, r_result_lo};
               f_out    <= w_hi_flags;
               alu_x    <= 8'h00;
               alu_y    <= 8'h00;
               alu_f_in <= 8'h00;
               alu_func <= ALU_FUNC_ADD;
               busy     <= 1'b0;
               done     <= 1'b1;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu16_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu16_seq : bench for alu16_seq with a behavioural byte ALU and a  |
// |                16-bit arithmetic reference model.                      |
// | Revision     : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_alu16_seq;

   localparam logic [3:0] ALU_FUNC_ADD = 4'h0;
   localparam logic [3:0] ALU_FUNC_ADC = 4'h1;
   localparam logic [3:0] ALU_FUNC_SUB = 4'h2;
   localparam logic [3:0] ALU_FUNC_SBC = 4'h3;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic [7:0]  f_in;
   logic        busy, done;
   logic [15:0] result;
   logic [7:0]  f_out, alu_x, alu_y, alu_f_in, alu_out, alu_f;
   logic [3:0]  alu_func;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: phase 0 idle, 1 low byte, 2 high byte, 3 done
   int          m_phase;
   logic [15:0] m_a, m_b, m_result;
   logic [1:0]  m_op;
   logic [7:0]  m_f, m_fout;
   logic        m_carry_lo;

   alu16_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .f_in(f_in),
      .busy(busy), .done(done), .result(result), .f_out(f_out),
      .alu_x(alu_x), .alu_y(alu_y), .alu_func(alu_func), .alu_f_in(alu_f_in),
      .alu_out(alu_out), .alu_f(alu_f)
   );

   always #5 clk = ~clk;

   // Behavioural 8-bit ALU, flags {S,Z,5,H,3,V,N,C}
   function automatic logic [15:0] alu8(input logic [3:0] fn, input logic [7:0] x, y, fi);
      int xi, yi, ci, r, rl;
      logic sub, c, h, v;
      logic [7:0] res;
      xi = x; yi = y;
      sub = (fn == ALU_FUNC_SUB) || (fn == ALU_FUNC_SBC);
      ci  = ((fn == ALU_FUNC_ADC) || (fn == ALU_FUNC_SBC)) ? int'(fi[0]) : 0;
      if (!sub) begin
         r = xi + yi + ci; rl = (xi & 15) + (yi & 15) + ci;
         c = (r > 255); h = (rl > 15);
      end else begin
         r = xi - yi - ci; rl = (xi & 15) - (yi & 15) - ci;
         c = (r < 0); h = (rl < 0);
      end
      res = r[7:0];
      v = sub ? ((x[7] != y[7]) && (res[7] != x[7])) : ((x[7] == y[7]) && (res[7] != x[7]));
      alu8 = {res[7], res == 8'h00, res[5], h, res[3], v, sub, c, res};
   endfunction

   assign {alu_f, alu_out} = alu8(alu_func, alu_x, alu_y, alu_f_in);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] lo_func(input logic [1:0] o);
      case (o)
         2'b00:   lo_func = ALU_FUNC_ADD;
         2'b01:   lo_func = ALU_FUNC_ADC;
         2'b10:   lo_func = ALU_FUNC_SBC;
         default: lo_func = ALU_FUNC_SUB;
      endcase
   endfunction

   // Whole-word arithmetic: result, carry/borrow out of bit 15, half carry at bit 11
   task automatic ref16();
      int ai, bi, ci, r, rl;
      logic sub, c, h, v;
      logic [15:0] res;
      ai = m_a; bi = m_b;
      sub = m_op[1];
      ci = (m_op == 2'b01 || m_op == 2'b10) ? int'(m_f[0]) : 0;
      if (!sub) begin
         r = ai + bi + ci; rl = (ai & 'hFFF) + (bi & 'hFFF) + ci;
         c = (r > 'hFFFF); h = (rl > 'hFFF);
      end else begin
         r = ai - bi - ci; rl = (ai & 'hFFF) - (bi & 'hFFF) - ci;
         c = (r < 0); h = (rl < 0);
      end
      res = r[15:0];
      v = sub ? ((m_a[15] != m_b[15]) && (res[15] != m_a[15]))
              : ((m_a[15] == m_b[15]) && (res[15] != m_a[15]));
      m_result = res;
      if (m_op == 2'b00)
         m_fout = {m_f[7], m_f[6], m_f[5], h, m_f[3], m_f[2], 1'b0, c};
      else
         m_fout = {res[15], res == 16'h0000, m_f[5], h, m_f[3], v, sub, c};
   endtask

   task automatic model_reset();
      m_phase = 0; m_result = 16'h0000; m_fout = 8'h00; m_carry_lo = 1'b0;
   endtask

   task automatic model_edge();
      int ci;
      if (reset) begin
         model_reset();
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_a = a; m_b = b; m_op = op; m_f = f_in; m_phase = 1;
               end
            1: begin
                  ci = (m_op == 2'b01 || m_op == 2'b10) ? int'(m_f[0]) : 0;
                  if (!m_op[1]) m_carry_lo = (int'(m_a[7:0]) + int'(m_b[7:0]) + ci) > 255;
                  else          m_carry_lo = (int'(m_a[7:0]) - int'(m_b[7:0]) - ci) < 0;
                  m_phase = 2;
               end
            2: begin ref16(); m_phase = 3; end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic check_outputs();
      logic [7:0] ex, ey, ef;
      logic [3:0] efn;
      ex = 8'h00; ey = 8'h00; ef = 8'h00; efn = ALU_FUNC_ADD;
      if (m_phase == 1) begin
         ex = m_a[7:0]; ey = m_b[7:0]; ef = m_f; efn = lo_func(m_op);
      end else if (m_phase == 2) begin
         ex = m_a[15:8]; ey = m_b[15:8]; ef = {m_f[7:1], m_carry_lo};
         efn = m_op[1] ? ALU_FUNC_SBC : ALU_FUNC_ADC;
      end
      chk("busy", busy, (m_phase == 1 || m_phase == 2));
      chk("done", done, (m_phase == 3));
      chk("busy_done_excl", busy & done, 0);
      chk("result", result, m_result);
      chk("f_out", f_out, m_fout);
      chk("alu_x", alu_x, ex);
      chk("alu_y", alu_y, ey);
      chk("alu_func", alu_func, efn);
      chk("alu_f_in", alu_f_in, ef);
   endtask

   task automatic cycle(input logic rst, input logic st, input logic [1:0] o,
                        input logic [15:0] aa, input logic [15:0] bb, input logic [7:0] ff);
      @(negedge clk);
      check_outputs();
      reset = rst; start = st; op = o; a = aa; b = bb; f_in = ff;
      @(posedge clk);
      model_edge();
   endtask

   task automatic rnd_cycle(input logic st);
      cycle(1'b0, st, 2'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4 && m_phase != 0; i++) rnd_cycle(1'b0);
   endtask

   // Operands are scrambled during LO/HI to show the latched copy is used
   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] aa, bb,
                         input logic [7:0] ff, input logic [15:0] er, input logic [7:0] ef);
      wait_idle();
      cycle(1'b0, 1'b1, o, aa, bb, ff);
      rnd_cycle(1'b1);
      rnd_cycle(1'b1);
      #1;
      chk({tag, "_result"}, result, er);
      chk({tag, "_flags"}, f_out, ef);
      chk({tag, "_done"}, done, 1'b1);
      rnd_cycle(1'b1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = 16'h0; b = 16'h0; f_in = 8'h0;
      model_reset();
      cycle(1'b1, 1'b1, 2'b00, 16'h1111, 16'h2222, 8'hFF);
      cycle(1'b0, 1'b1, 2'b01, 16'h0001, 16'h0002, 8'h01);
      rnd_cycle(1'b0);
      rnd_cycle(1'b0);
      rnd_cycle(1'b0);

      run_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 8'hC4, 16'h0000, 8'hD5);
      run_op("adc_ovf",  2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94);
      run_op("sbc_zero", 2'b10, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42);
      run_op("sub_brw",  2'b11, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h12);

      // Abort in HI: async clear must be visible before the next edge
      wait_idle();
      cycle(1'b0, 1'b1, 2'b01, 16'hABCD, 16'h1357, 8'h00);
      rnd_cycle(1'b0);
      @(negedge clk);
      check_outputs();
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_result", result, 16'h0000);
      chk("abort_f_out", f_out, 8'h00);
      chk("abort_alu_x", alu_x, 8'h00);
      model_reset();
      @(posedge clk);
      model_edge();
      cycle(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 8'h0);
      run_op("post_rst", 2'b00, 16'h0F0F, 16'h00F1, 8'h00, 16'h1000, 8'h10);

      for (int i = 0; i < 60; i++) rnd_cycle(1'b1);
      for (int i = 0; i < 500; i++) rnd_cycle($urandom_range(0, 3) != 0);
      rnd_cycle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a 16-bit operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 ADD16, 01 ADC16, 10 SBC16, 11 SUB16.
REQ-006 a  input  16  first operand (minuend for SBC16/SUB16).
REQ-007 b  input  16  second operand.
REQ-008 f_in  input  8  incoming flags, bit order S Z 5 H 3 V N C (bit7..bit0).
REQ-009 busy  output  1  high while in LO or HI.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  16  last completed 16-bit result.
REQ-012 f_out  output  8  last completed flags, same bit order as f_in.
REQ-013 alu_x, alu_y  output  8 each  operand bytes driven to the external alu8 instance.
REQ-014 alu_func  output  4  function code driven to alu8, using the ALU_FUNC_* encodings.
REQ-015 alu_f_in  output  8  flags driven to alu8.
REQ-016 alu_out, alu_f  input  8 each  combinational result and flags returned by alu8.

Function
REQ-017 FSM states: IDLE, LO, HI, DONE.
- IDLE->LO when start=1.
- LO->HI unconditionally.
- HI->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-018 On the IDLE edge that accepts start, the block latches a, b, op and f_in; later input changes do not affect the operation in flight.
REQ-019 start is ignored in LO, HI and DONE; no queueing.
REQ-020 LO drives the following to alu8:
- alu_x=a_q[7:0], alu_y=b_q[7:0], alu_f_in=f_in_q.
- alu_func: ADD (ADD16), ADC (ADC16), SBC (SBC16), SUB (SUB16).
REQ-021 LO registers alu_out into result_lo and alu_f[0] into carry_lo; it also registers (alu_out==0) into zero_lo.
REQ-022 HI drives the following to alu8:
- alu_x=a_q[15:8], alu_y=b_q[15:8], alu_f_in={f_in_q[7:1], carry_lo}.
- alu_func: ADC for ADD16/ADC16, SBC for SBC16/SUB16.
REQ-023 At the end of HI the block loads result={alu_out, result_lo} and loads f_out per REQ-024/025.
REQ-024 ADD16 flags:
- S, Z, V, 5, 3 = f_in_q bits 7, 6, 2, 5, 3.
- H = alu_f[4], N = 0, C = alu_f[0].
REQ-025 ADC16/SBC16/SUB16 flags:
- S = alu_out[7], Z = (alu_out==0 && zero_lo).
- 5, 3 = f_in_q bits 5, 3.
- H = alu_f[4], V = alu_f[2], C = alu_f[0].
- N = 0 for ADC16, 1 for SBC16/SUB16.
REQ-026 done=1 only in DONE (exactly one cycle per accepted start); busy=1 only in LO and HI.
REQ-027 Latency: start accepted at edge k; result/f_out valid after edge k+2; done high during cycle k+2..k+3; earliest next start accepted at edge k+4.
REQ-028 In IDLE and DONE: alu_x=alu_y=0, alu_func=ALU_FUNC_ADD, alu_f_in=0.
REQ-029 result and f_out hold their values until the next HI completes; they are not altered in IDLE, LO or DONE.
REQ-030 Wrap-around: the 16-bit result is taken modulo 2^16; the carry/borrow appears only in C.

Reset
REQ-031 While reset=1, asynchronously:
- state=IDLE, busy=0, done=0.
- result=0, f_out=0, result_lo=0, carry_lo=0, zero_lo=0.
- ALU drive per REQ-028.
REQ-032 Reset asserted in LO, HI or DONE aborts the operation: no done pulse, and result/f_out read 0.
REQ-033 start high on the first edge after reset deasserts is accepted normally.

Verification
REQ-034 ADD16 a=FFFF b=0001 f_in=C4 -> result=0000, f_out=D5 (S,Z,V kept, H=1, N=0, C=1), done after 3 edges.
REQ-035 ADC16 a=7FFF b=0000 f_in=01 -> result=8000; S=1, Z=0, H=1, V=1, N=0, C=0.
REQ-036 SBC16 a=1234 b=1234 with no borrow in -> result=0000, Z=1, S=0, N=1; SUB16 a=1000 b=0001 -> result=0FFF, Z=0, N=1.
REQ-037 start held high continuously -> operations accepted every 4th edge, one done per operation; a and b changed during LO do not change result.
REQ-038 reset pulsed during HI -> done never asserts, result=0000, f_out=00, state IDLE; the next start completes correctly.
REQ-039 Every cycle -> busy and done never both high, and ALU drive values match REQ-020/022/028 for the current state.
